fb_access_arbiter: RTL and testbench

Shares one single-port synchronous framebuffer RAM between three clients:
- the 640x480 scanout path, driven by the VGA timing generator's pixel strobe, active flag and x/y;
- a clear engine that wipes the whole framebuffer;
- the ant-simulation read/write client.

Fixed priority is display > clear > sim. The display is never stalled; the other two use the leftover cycles.

---
 rtl/fb_access_arbiter_if.sv | 35 +++
 rtl/fb_access_arbiter.sv | 173 +++++++++++++++++
 tb/tb_fb_access_arbiter.sv | 475 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_access_arbiter_if.sv
// Sim-client handshake and framebuffer RAM port bundle.
// master = arbiter side, slave = client / RAM side.
interface fb_access_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
);
  logic              sim_req;
  logic              sim_we;
  logic [ADDR_W-1:0] sim_addr;
  logic [DATA_W-1:0] sim_wdata;
  logic              sim_gnt;
  logic              sim_rvalid;
  logic [DATA_W-1:0] sim_rdata;
  logic [15:0]       sim_stall_cnt;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  sim_req, sim_we, sim_addr, sim_wdata,
    input  mem_rdata,
    output sim_gnt, sim_rvalid, sim_rdata,
    output sim_stall_cnt,
    output mem_addr, mem_we, mem_wdata
  );

  modport slave (
    output sim_req, sim_we, sim_addr, sim_wdata,
    output mem_rdata,
    input  sim_gnt, sim_rvalid, sim_rdata,
    input  sim_stall_cnt,
    input  mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/fb_access_arbiter.sv
// Single-port framebuffer arbiter: display > clear > sim.
// Reads return through a 2-stage tag pipe, 3 cycles after the slot.
module fb_access_arbiter #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int DEPTH  = H_RES * V_RES,
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_pix_stb,
  input  logic              i_active,
  input  logic [9:0]        i_x,
  input  logic [8:0]        i_y,
  output logic [DATA_W-1:0] o_pix_data,
  output logic              o_pix_valid,
  input  logic              i_clear_start,
  output logic              o_clear_busy,
  output logic              o_clear_done,
  fb_access_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    SL_NONE, SL_DISP, SL_CLR, SL_SIM
  } slot_t;

  typedef enum logic [1:0] {
    TG_NONE, TG_DISP, TG_SIM, TG_OOB
  } tag_t;

  typedef enum logic [1:0] {
    C_IDLE, C_RUN, C_DONE
  } clr_t;

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0] DEPTH_X =
    (ADDR_W + 1)'(DEPTH);

  slot_t             slot;
  tag_t              tag0, tag1;
  clr_t              clr_state, clr_next;
  logic [ADDR_W-1:0] clr_ptr, ptr_next;
  logic [ADDR_W-1:0] disp_addr, x_w, y_w;
  logic              disp_req, sim_oob;

  assign x_w = ADDR_W'(i_x);
  assign y_w = ADDR_W'(i_y);

  generate
    if (H_RES == 640) begin : g_shift
      assign disp_addr = (y_w << 9) + (y_w << 7) + x_w;
    end else begin : g_mul
      assign disp_addr = y_w * ADDR_W'(H_RES) + x_w;
    end
  endgenerate

  assign disp_req = i_pix_stb & i_active;
  assign sim_oob  = {1'b0, bus.sim_addr} >= DEPTH_X;

  assign o_clear_busy = (clr_state == C_RUN);
  assign o_clear_done = (clr_state == C_DONE);

  always_comb begin
    slot = SL_NONE;
    if (disp_req)
      slot = SL_DISP;
    else if (o_clear_busy)
      slot = SL_CLR;
    else if (bus.sim_req)
      slot = SL_SIM;
  end

  assign bus.sim_gnt = bus.sim_req & (slot == SL_SIM);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      clr_state <= C_IDLE;
      clr_ptr   <= '0;
    end else begin
      clr_state <= clr_next;
      clr_ptr   <= ptr_next;
    end
  end

  always_comb begin
    clr_next = clr_state;
    ptr_next = clr_ptr;
    unique case (clr_state)
      C_IDLE: begin
        if (i_clear_start) begin
          clr_next = C_RUN;
          ptr_next = '0;
        end
      end
      C_RUN: begin
        if (slot == SL_CLR) begin
          if (clr_ptr == LAST)
            clr_next = C_DONE;
          else
            ptr_next = clr_ptr + 1'b1;
        end
      end
      C_DONE: begin
        clr_next = C_IDLE;
        ptr_next = '0;
      end
      default: clr_next = C_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bus.mem_addr      <= '0;
      bus.mem_we        <= 1'b0;
      bus.mem_wdata     <= '0;
      tag0              <= TG_NONE;
      tag1              <= TG_NONE;
      o_pix_data        <= '0;
      o_pix_valid       <= 1'b0;
      bus.sim_rvalid    <= 1'b0;
      bus.sim_rdata     <= '0;
      bus.sim_stall_cnt <= '0;
    end else begin
      bus.mem_we     <= 1'b0;
      tag0           <= TG_NONE;
      o_pix_valid    <= 1'b0;
      bus.sim_rvalid <= 1'b0;
      unique case (slot)
        SL_DISP: begin
          bus.mem_addr <= disp_addr;
          tag0         <= TG_DISP;
        end
        SL_CLR: begin
          bus.mem_addr  <= clr_ptr;
          bus.mem_we    <= 1'b1;
          bus.mem_wdata <= CLEAR_VAL;
        end
        SL_SIM: begin
          bus.mem_addr  <= bus.sim_addr;
          bus.mem_we    <= bus.sim_we & ~sim_oob;
          bus.mem_wdata <= bus.sim_wdata;
          if (!bus.sim_we)
            tag0 <= sim_oob ? TG_OOB : TG_SIM;
        end
        SL_NONE: ;
      endcase
      tag1 <= tag0;
      // tag1 lines up with the RAM data now on mem_rdata
      unique case (tag1)
        TG_DISP: begin
          o_pix_data  <= bus.mem_rdata;
          o_pix_valid <= 1'b1;
        end
        TG_SIM: begin
          bus.sim_rdata  <= bus.mem_rdata;
          bus.sim_rvalid <= 1'b1;
        end
        TG_OOB: begin
          bus.sim_rdata  <= '0;
          bus.sim_rvalid <= 1'b1;
        end
        TG_NONE: ;
      endcase
      if (bus.sim_req && !bus.sim_gnt &&
          bus.sim_stall_cnt != 16'hFFFF)
        bus.sim_stall_cnt <= bus.sim_stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Bench for fb_access_arbiter: 640x8 framebuffer, behavioural
// RAM model plus a shadow memory and queued expected read returns.
module tb_fb_access_arbiter;
  localparam int H  = 640;
  localparam int V  = 8;
  localparam int D  = H * V;
  localparam int AW = 19;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, stb, act, cstart, load;
  logic [9:0]    x;
  logic [8:0]    y;
  logic [DW-1:0] pix_data;
  logic          pix_valid, busy, done;

  fb_access_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  fb_access_arbiter #(
    .H_RES(H), .V_RES(V), .ADDR_W(AW), .DATA_W(DW)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_pix_stb(stb), .i_active(act),
    .i_x(x), .i_y(y),
    .o_pix_data(pix_data), .o_pix_valid(pix_valid),
    .i_clear_start(cstart),
    .o_clear_busy(busy), .o_clear_done(done),
    .bus(bus)
  );

  logic [7:0] ram [D];
  logic [7:0] ref_mem [D];

  always @(posedge clk) begin
    if (load) begin
      for (int a = 0; a < D; a++)
        ram[a] <= 8'((a % H) ^ (a / H));
    end else if (bus.mem_we && 32'(bus.mem_addr) < D)
      ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= (32'(bus.mem_addr) < D) ?
      ram[bus.mem_addr] : 8'hEE;
  end

  typedef struct { int due; logic [7:0] d; } ev_t;

  int n_pass = 0;
  int n_total = 0;
  int m_stall = 0;

  task automatic pulse_reset();
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    m_stall = 0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1; load = 1'b0;
    @(negedge clk);
    n_total++;
    if ({pix_valid, pix_data} !== 9'd0)
      $display("FAIL reset_pix: got %b/%h want 0/00",
               pix_valid, pix_data);
    else n_pass++;
    n_total++;
    if ({busy, done} !== 2'b00)
      $display("FAIL reset_clear: got busy=%b done=%b want 0 0",
               busy, done);
    else n_pass++;
    n_total++;
    if ({bus.sim_rvalid, bus.sim_rdata} !== 9'd0)
      $display("FAIL reset_sim_r: got %b/%h want 0/00",
               bus.sim_rvalid, bus.sim_rdata);
    else n_pass++;
    n_total++;
    if (bus.sim_stall_cnt !== 16'd0)
      $display("FAIL reset_stall: got %h want 0000",
               bus.sim_stall_cnt);
    else n_pass++;
    n_total++;
    if ({bus.mem_addr, bus.mem_we, bus.mem_wdata} !== '0)
      $display("FAIL reset_mem: got %h/%b/%h want 0/0/0",
               bus.mem_addr, bus.mem_we, bus.mem_wdata);
    else n_pass++;
    @(posedge clk); #1; rst = 1'b0;
    m_stall = 0;
  endtask

  task automatic test_display();
    int nval = 0;
    int bad = 0;
    int first = -1;
    logic ev;
    logic [7:0] ed;
    for (int i = 0; i < H * 4 + 4; i++) begin
      @(posedge clk); #1;
      act = (i / 4 < H);
      stb = (i % 4 == 0) && (i / 4 < H);
      x = (i / 4 < H) ? 10'(i / 4) : 10'd0;
      y = 9'd5;
      @(negedge clk);
      ev = (i >= 3) && ((i - 3) % 4 == 0) && ((i - 3) / 4 < H);
      ed = ev ? ref_mem[5 * H + (i - 3) / 4] : 8'h00;
      if (pix_valid) nval++;
      if (pix_valid !== ev || (ev && pix_data !== ed)) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    n_total++;
    if (nval !== H)
      $display("FAIL disp_count: got %0d want %0d", nval, H);
    else n_pass++;
    n_total++;
    if (bad !== 0)
      $display("FAIL disp_seq: got %0d bad cycles (first %0d) want 0",
               bad, first);
    else n_pass++;
    n_total++;
    if (pix_data !== ref_mem[5 * H + H - 1])
      $display("FAIL disp_hold: got %h want %h",
               pix_data, ref_mem[5 * H + H - 1]);
    else n_pass++;
  endtask

  task automatic test_sim_stall();
    int bad = 0;
    int bad_r = 0;
    logic [7:0] ed;
    bus.sim_req = 1'b1; bus.sim_we = 1'b1;
    bus.sim_addr = 19'd1000; bus.sim_wdata = 8'hA5;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      act = 1'b1;
      stb = (i % 4 == 0);
      x = 10'($urandom % H);
      y = 9'($urandom % V);
      @(negedge clk);
      if (bus.sim_gnt !== !stb) bad++;
      if (stb) m_stall++;
      if (!stb) ref_mem[1000] = 8'hA5;
    end
    @(posedge clk); #1;
    bus.sim_req = 1'b0; stb = 1'b0;
    @(negedge clk);
    n_total++;
    if (bad !== 0)
      $display("FAIL stall_gnt: got %0d wrong gnt cycles want 0", bad);
    else n_pass++;
    n_total++;
    if (bus.sim_stall_cnt !== 16'(m_stall))
      $display("FAIL stall_cnt: got %0d want %0d",
               bus.sim_stall_cnt, m_stall);
    else n_pass++;
    @(posedge clk); #1;
    bus.sim_req = 1'b1; bus.sim_we = 1'b0;
    @(negedge clk);
    ed = ref_mem[1000];
    n_total++;
    if (bus.sim_gnt !== 1'b1)
      $display("FAIL rd1000_gnt: got %b want 1", bus.sim_gnt);
    else n_pass++;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      bus.sim_req = 1'b0;
      @(negedge clk);
      if (bus.sim_rvalid !== (k == 3)) bad_r++;
      if (k == 3) begin
        n_total++;
        if (bus.sim_rdata !== ed)
          $display("FAIL rd1000_data: got %h want %h",
                   bus.sim_rdata, ed);
        else n_pass++;
      end
    end
    n_total++;
    if (bad_r !== 0)
      $display("FAIL rd1000_lat: got %0d bad rvalid cycles want 0",
               bad_r);
    else n_pass++;
  endtask

  task automatic test_oob();
    logic [18:0] ra [3];
    logic [18:0] wa [2];
    logic [7:0] ed;
    int bad;
    ra[0] = 19'(D - 1); ra[1] = 19'(D); ra[2] = 19'd307200;
    wa[0] = 19'(D); wa[1] = 19'd400000;
    stb = 1'b0;
    for (int j = 0; j < 3; j++) begin
      bad = 0;
      @(posedge clk); #1;
      bus.sim_req = 1'b1; bus.sim_we = 1'b0;
      bus.sim_addr = ra[j];
      @(negedge clk);
      ed = (32'(ra[j]) < D) ? ref_mem[ra[j]] : 8'h00;
      n_total++;
      if (bus.sim_gnt !== 1'b1)
        $display("FAIL oob_rd_gnt: addr %0d got %b want 1",
                 ra[j], bus.sim_gnt);
      else n_pass++;
      for (int k = 1; k <= 4; k++) begin
        @(posedge clk); #1;
        bus.sim_req = 1'b0;
        @(negedge clk);
        if (bus.sim_rvalid !== (k == 3)) bad++;
        if (k == 3 && bus.sim_rdata !== ed) bad++;
      end
      n_total++;
      if (bad !== 0)
        $display("FAIL oob_rd: addr %0d got %0d errs rdata %h want %h",
                 ra[j], bad, bus.sim_rdata, ed);
      else n_pass++;
    end
    for (int j = 0; j < 2; j++) begin
      @(posedge clk); #1;
      bus.sim_req = 1'b1; bus.sim_we = 1'b1;
      bus.sim_addr = wa[j]; bus.sim_wdata = 8'h3C;
      @(negedge clk);
      n_total++;
      if (bus.sim_gnt !== 1'b1)
        $display("FAIL oob_wr_gnt: addr %0d got %b want 1",
                 wa[j], bus.sim_gnt);
      else n_pass++;
      @(posedge clk); #1;
      bus.sim_req = 1'b0;
      @(negedge clk);
      n_total++;
      if (bus.sim_we !== 1'b1 || bus.mem_we !== 1'b0)
        $display("FAIL oob_wr_we: addr %0d got %b want 0",
                 wa[j], bus.mem_we);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    localparam int N = 1000;
    ev_t pq[$];
    ev_t sq[$];
    int bad_g = 0;
    int bad_p = 0;
    int bad_s = 0;
    logic pend = 1'b0;
    logic p_we = 1'b0;
    logic [18:0] p_addr = '0;
    logic [7:0] p_wd = '0;
    logic eg, sa;
    for (int i = 0; i < N + 4; i++) begin
      @(posedge clk); #1;
      if (i % 32 == 0) act = ($urandom % 4 != 0);
      stb = (i % 4 == 0) && (i < N);
      x = 10'($urandom % H);
      y = 9'($urandom % V);
      if (!pend && i < N && ($urandom % 4 != 0)) begin
        pend = 1'b1;
        p_we = 1'($urandom % 2);
        p_addr = ($urandom % 8 == 0) ?
          19'(D + $urandom % 50) : 19'($urandom % D);
        p_wd = 8'($urandom);
      end
      bus.sim_req = pend; bus.sim_we = p_we;
      bus.sim_addr = p_addr; bus.sim_wdata = p_wd;
      @(negedge clk);
      if (pq.size() > 0 && pq[0].due == i) begin
        if (pix_valid !== 1'b1 || pix_data !== pq[0].d) bad_p++;
        void'(pq.pop_front());
      end else if (pix_valid !== 1'b0) bad_p++;
      if (sq.size() > 0 && sq[0].due == i) begin
        if (bus.sim_rvalid !== 1'b1 || bus.sim_rdata !== sq[0].d)
          bad_s++;
        void'(sq.pop_front());
      end else if (bus.sim_rvalid !== 1'b0) bad_s++;
      sa = stb && act;
      eg = pend && !sa;
      if (bus.sim_gnt !== eg) bad_g++;
      if (pend && sa) m_stall++;
      if (sa) pq.push_back('{i + 3, ref_mem[int'(y) * H + int'(x)]});
      if (eg) begin
        if (p_we) begin
          if (32'(p_addr) < D) ref_mem[p_addr] = p_wd;
        end else
          sq.push_back('{i + 3,
            (32'(p_addr) < D) ? ref_mem[p_addr] : 8'h00});
        pend = 1'b0;
      end
    end
    n_total++;
    if (bad_g !== 0)
      $display("FAIL rnd_gnt: got %0d wrong cycles want 0", bad_g);
    else n_pass++;
    n_total++;
    if (bad_p !== 0)
      $display("FAIL rnd_pix: got %0d wrong cycles want 0", bad_p);
    else n_pass++;
    n_total++;
    if (bad_s !== 0 || pq.size() + sq.size() !== 0)
      $display("FAIL rnd_sim_rd: got %0d errs %0d left want 0 0",
               bad_s, pq.size() + sq.size());
    else n_pass++;
    n_total++;
    if (bus.sim_stall_cnt !== 16'(m_stall))
      $display("FAIL rnd_stall: got %0d want %0d",
               bus.sim_stall_cnt, m_stall);
    else n_pass++;
  endtask

  task automatic test_clear();
    int nwr = 0;
    int bad_wr = 0;
    int bad_g = 0;
    int bad_b = 0;
    int ndone = 0;
    int done_c = -1;
    int fall_c = -2;
    logic gnt_fall = 1'b0;
    logic pbusy = 1'b0;
    act = 1'b0;
    bus.sim_req = 1'b1; bus.sim_we = 1'b0;
    bus.sim_addr = 19'd7;
    for (int i = 0; i < D + 200; i++) begin
      @(posedge clk); #1;
      cstart = (i == 0) || (i == 2000);
      stb = (i % 4 == 0);
      @(negedge clk);
      if (i == 0 && busy !== 1'b0) bad_b++;
      if (i == 1 && busy !== 1'b1) bad_b++;
      if (busy && bus.sim_gnt) bad_g++;
      if (bus.mem_we) begin
        if (32'(bus.mem_addr) != nwr || bus.mem_wdata !== 8'h00)
          bad_wr++;
        nwr++;
      end
      if (done) begin
        ndone++;
        done_c = i;
      end
      if (pbusy && !busy) begin
        fall_c = i;
        gnt_fall = bus.sim_gnt;
      end
      pbusy = busy;
      if (ndone > 0 && i >= done_c + 3) break;
    end
    bus.sim_req = 1'b0; cstart = 1'b0; stb = 1'b0;
    for (int a = 0; a < D; a++) ref_mem[a] = 8'h00;
    n_total++;
    if (nwr !== D || bad_wr !== 0)
      $display("FAIL clr_writes: got %0d writes %0d bad want %0d 0",
               nwr, bad_wr, D);
    else n_pass++;
    n_total++;
    if (ndone !== 1)
      $display("FAIL clr_done: got %0d pulses want 1", ndone);
    else n_pass++;
    n_total++;
    if (bad_g !== 0 || bad_b !== 0)
      $display("FAIL clr_busy_gnt: got %0d gnt %0d busy errs want 0",
               bad_g, bad_b);
    else n_pass++;
    n_total++;
    if (gnt_fall !== 1'b1 || fall_c !== done_c)
      $display("FAIL clr_release: got gnt=%b fall=%0d done=%0d want 1",
               gnt_fall, fall_c, done_c);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (ram[D - 1] !== ref_mem[D - 1])
      $display("FAIL clr_ram: got %h want %h",
               ram[D - 1], ref_mem[D - 1]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int nwr = 0;
    int bad = 0;
    int k = 0;
    logic [18:0] got [3];
    got[0] = '1; got[1] = '1; got[2] = '1;
    bus.sim_req = 1'b0; stb = 1'b0; act = 1'b0;
    @(posedge clk); #1; cstart = 1'b1;
    for (int i = 0; i < 2000 && nwr < 1000; i++) begin
      @(negedge clk);
      if (bus.mem_we) nwr++;
      if (done) bad++;
      @(posedge clk); #1; cstart = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    if (done) bad++;
    @(posedge clk); #1; rst = 1'b0;
    m_stall = 0;
    @(negedge clk);
    n_total++;
    if (busy !== 1'b0 || bus.mem_we !== 1'b0)
      $display("FAIL rstmid_busy: got busy=%b we=%b want 0 0",
               busy, bus.mem_we);
    else n_pass++;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy || bus.mem_we) bad++;
    end
    n_total++;
    if (bad !== 0)
      $display("FAIL rstmid_quiet: got %0d bad cycles want 0", bad);
    else n_pass++;
    @(posedge clk); #1; cstart = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.mem_we && k < 3) begin
        got[k] = bus.mem_addr;
        k++;
      end
      @(posedge clk); #1; cstart = 1'b0;
    end
    n_total++;
    if (got[0] !== 19'd0 || got[1] !== 19'd1 || got[2] !== 19'd2)
      $display("FAIL rstmid_restart: got %0d %0d %0d want 0 1 2",
               got[0], got[1], got[2]);
    else n_pass++;
    pulse_reset();
  endtask

  task automatic test_stall_sat();
    int bad = 0;
    bus.sim_req = 1'b1; bus.sim_we = 1'b0;
    bus.sim_addr = '0;
    stb = 1'b1; act = 1'b1; x = '0; y = '0;
    for (int i = 0; i < 65600; i++) begin
      @(negedge clk);
      if (bus.sim_gnt !== 1'b0) bad++;
      if (m_stall < 65535) m_stall++;
    end
    @(negedge clk);
    n_total++;
    if (bad !== 0)
      $display("FAIL sat_gnt: got %0d grants want 0", bad);
    else n_pass++;
    n_total++;
    if (bus.sim_stall_cnt !== 16'(m_stall))
      $display("FAIL sat_cnt: got %h want %h",
               bus.sim_stall_cnt, 16'(m_stall));
    else n_pass++;
    repeat (8) @(negedge clk);
    n_total++;
    if (bus.sim_stall_cnt !== 16'(m_stall))
      $display("FAIL sat_hold: got %h want %h",
               bus.sim_stall_cnt, 16'(m_stall));
    else n_pass++;
    @(posedge clk); #1;
    bus.sim_req = 1'b0; stb = 1'b0; act = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load = 1'b1;
    stb = 1'b0; act = 1'b0; cstart = 1'b0;
    x = '0; y = '0;
    bus.sim_req = 1'b0; bus.sim_we = 1'b0;
    bus.sim_addr = '0; bus.sim_wdata = '0;
    for (int a = 0; a < D; a++)
      ref_mem[a] = 8'((a % H) ^ (a / H));
    test_reset();
    test_display();
    test_sim_stall();
    test_oob();
    test_random();
    test_clear();
    test_reset_mid();
    test_stall_sat();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
